// File: rtl/exp7_unidade_controle.sv
// Memory-game control unit: Moore FSM sequencing rounds, plays, comparison and end states.
// Also owns the per-play timeout counter, so the datapath needs no timer of its own.
module exp7_unidade_controle #(
    parameter int unsigned TIMEOUT_CYCLES = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       rodadaFinal,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned OUT_W = 13;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIO_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_GANHOU    = 4'hA,
        FIM_PERDEU    = 4'hE,
        FIM_TIMEOUT   = 4'hF
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               timeout_hit;

    assign timeout_hit = (timer == TIMER_LAST);

    // Next-state decision; jogada takes priority over timeout in ESPERA.
    function automatic state_t f_next(input state_t s, input logic ini, input logic jog,
                                      input logic ig, input logic eir, input logic rf,
                                      input logic tmo);
        state_t n;
        n = INICIAL;
        case (s)
            INICIAL:       n = ini ? PREPARA : INICIAL;
            PREPARA:       n = INICIO_RODADA;
            INICIO_RODADA: n = ESPERA;
            ESPERA:        n = jog ? REGISTRA : (tmo ? FIM_TIMEOUT : ESPERA);
            REGISTRA:      n = COMPARA;
            COMPARA: begin
                if (!ig)            n = FIM_PERDEU;
                else if (eir && rf) n = FIM_GANHOU;
                else if (eir)       n = PROX_RODADA;
                else                n = PROX_JOGADA;
            end
            PROX_JOGADA:   n = ESPERA;
            PROX_RODADA:   n = INICIO_RODADA;
            FIM_GANHOU:    n = ini ? PREPARA : FIM_GANHOU;
            FIM_PERDEU:    n = ini ? PREPARA : FIM_PERDEU;
            FIM_TIMEOUT:   n = ini ? PREPARA : FIM_TIMEOUT;
            default:       n = INICIAL;
        endcase
        return n;
    endfunction

    // Moore output decode: {zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout, db_estado}.
    function automatic logic [OUT_W-1:0] f_out(input state_t s);
        logic [8:0] f;
        f = 9'b0;
        case (s)
            PREPARA:       f = 9'b1_0_1_0_0_0_0_0_0;
            INICIO_RODADA: f = 9'b1_0_0_0_0_0_0_0_0;
            REGISTRA:      f = 9'b0_0_0_0_1_0_0_0_0;
            PROX_JOGADA:   f = 9'b0_1_0_0_0_0_0_0_0;
            PROX_RODADA:   f = 9'b0_0_0_1_0_0_0_0_0;
            FIM_GANHOU:    f = 9'b0_0_0_0_0_1_1_0_0;
            FIM_PERDEU:    f = 9'b0_0_0_0_0_1_0_1_0;
            FIM_TIMEOUT:   f = 9'b0_0_0_0_0_1_0_1_1;
            default:       f = 9'b0;
        endcase
        return {f, 4'(s)};
    endfunction

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INICIAL;
            timer <= '0;
            {zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout,
             db_estado} <= '0;
        end else begin
            state <= f_next(state, iniciar, jogada, igual, enderecoIgualRodada, rodadaFinal,
                            timeout_hit);
            timer <= (state == ESPERA && !jogada && !timeout_hit) ? timer + TIMER_W'(1) : '0;
            {zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout,
             db_estado} <= f_out(f_next(state, iniciar, jogada, igual, enderecoIgualRodada,
                                        rodadaFinal, timeout_hit));
        end
    end

endmodule
